fifo_nibble_reader: RTL

Drain-side client for the team's 4-bit FIFO. It pops nibbles from the FIFO, pairs them low-nibble-first into bytes, and presents each byte downstream on a valid/ready handshake. It tolerates the FIFO's registered `empty` flag (one cycle behind its internal count) and its registered read data (one cycle after the pop) by enforcing a minimum pop spacing. A flush timer emits a partial byte when the FIFO runs dry between the two nibbles.

---
 rtl/fifo_rd_pkg.sv | 23 ++
 rtl/pop_guard.sv | 29 ++
 rtl/fifo_nibble_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and widths for the nibble FIFO drain-side reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_rd_pkg;

  // Default FIFO nibble width; the output byte is twice this.
  localparam int DATA_W_DEF = 4;

  // Width of the pop-spacing guard counter (holds POP_GAP-1, POP_GAP <= 15).
  localparam int GUARD_W = 4;

  // Width of the flush timer (FLUSH_CYCLES <= 255).
  localparam int FLUSH_W = 8;

  typedef enum logic [2:0] {
    LO_REQ,
    LO_CAP,
    HI_REQ,
    HI_CAP,
    SEND
  } rd_state_t;

endpackage

// File: rtl/pop_guard.sv
// Spacing guard: blocks further FIFO accesses for a fixed number of cycles after each one.
// Latency: ready drops the cycle after load and returns load_val cycles later.
// Backpressure: none; load is sampled every cycle, ready is purely a status output.
module pop_guard #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         ready
);

  logic [W-1:0] count;

  // Load on an access, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign ready = (count == '0);

endmodule

// File: rtl/fifo_nibble_reader.sv
// Pops nibbles from the 4-bit FIFO, pairs them low-first into bytes, flushes a lone low nibble.
// Latency: first pop at t, hi pop at t+POP_GAP, out_valid from t+POP_GAP+2 (t+5 at POP_GAP=3).
// Backpressure: byte held stable in SEND until out_ready; no pops are issued while holding.
module fifo_nibble_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int POP_GAP      = 3,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data,
  output logic                fifo_pop,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_valid,
  output logic                out_partial,
  input  logic                out_ready
);

  localparam logic [GUARD_W-1:0] GAP_LOAD  = GUARD_W'(POP_GAP - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LIM = FLUSH_W'(FLUSH_CYCLES);
  localparam bit                 FLUSH_EN  = (FLUSH_CYCLES != 0);

  rd_state_t          state;
  rd_state_t          state_nxt;
  logic [DATA_W-1:0]  lo;
  logic [DATA_W-1:0]  hi;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               guard_rdy;
  logic               flush_hit;

  // The guard keeps pops POP_GAP apart so a pop never sees the FIFO's stale empty flag.
  pop_guard #(
    .W (GUARD_W)
  ) u_guard (
    .clk      (clk),
    .rst      (rst),
    .load     (fifo_pop),
    .load_val (GAP_LOAD),
    .ready    (guard_rdy)
  );

  assign fifo_pop = ((state == LO_REQ) || (state == HI_REQ)) && !fifo_empty && guard_rdy && !rst;

  assign flush_hit = FLUSH_EN && (flush_cnt == FLUSH_LIM);

  // The byte is driven straight from the nibble registers; they only change outside SEND.
  assign out_data = {hi, lo};

  // Next-state selection; a pop in HI_REQ takes priority over the flush timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      LO_REQ: if (fifo_pop) state_nxt = LO_CAP;
      LO_CAP: state_nxt = HI_REQ;
      HI_REQ: begin
        if (fifo_pop) begin
          state_nxt = HI_CAP;
        end else if (flush_hit) begin
          state_nxt = SEND;
        end
      end
      HI_CAP: state_nxt = SEND;
      SEND:   if (out_valid && out_ready) state_nxt = LO_REQ;
      default: state_nxt = LO_REQ;
    endcase
  end

  // State register plus nibble capture, flush timer and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LO_REQ;
      lo          <= '0;
      hi          <= '0;
      flush_cnt   <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        LO_CAP: begin
          lo        <= fifo_data;
          flush_cnt <= '0;
        end
        HI_REQ: begin
          if (!fifo_pop) begin
            if (flush_hit) begin
              hi          <= '0;
              out_partial <= 1'b1;
              out_valid   <= 1'b1;
            end else if (flush_cnt != '1) begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        HI_CAP: begin
          hi          <= fifo_data;
          out_partial <= 1'b0;
          out_valid   <= 1'b1;
        end
        SEND: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
